// File: rtl/intpol2_sched_pkg.sv
// Shared constants for the intpol2 channel scheduler: FSM state encodings,
// the start-to-busy acknowledge limit and default parameter values.
package intpol2_sched_pkg;

    localparam int NCH_DEF  = 4;
    localparam int CW_DEF   = 16;
    localparam int TO_W_DEF = 12;

    // Cycles the core may take to raise busy after a start pulse
    localparam int WB_LIMIT = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_ABORT     = 3'd4;

endpackage

// File: rtl/intpol2_rr_arb.sv
// Combinational round-robin arbiter: searches req starting one past the
// previous winner and wrapping around, returns one-hot and index forms.
module intpol2_rr_arb
    import intpol2_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last,
    output logic [NCH-1:0]         winner,
    output logic [$clog2(NCH)-1:0] winner_idx,
    output logic                   any
);

    localparam int IW = $clog2(NCH);

    // Priority search unrolled per possible previous winner
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        for (int unsigned s = 0; s < NCH; s++) begin
            if (last == IW'(s)) begin
                for (int unsigned k = 1; k <= NCH; k++) begin
                    if (!any && req[(s + k) % NCH]) begin
                        any                      = 1'b1;
                        winner[(s + k) % NCH]    = 1'b1;
                        winner_idx               = IW'((s + k) % NCH);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/intpol2_ch_sched.sv
// Round-robin scheduler sharing one intpol2_D4 core among NCH channels.
// Grants a channel, pulses core start, tracks busy/done, counts frames
// and aborts the core when a frame overruns the watchdog.
module intpol2_ch_sched
    import intpol2_sched_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int CW   = CW_DEF,
    parameter int TO_W = TO_W_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic [NCH-1:0]         ch_req,
    input  logic [NCH-1:0]         ch_en,
    input  logic [NCH-1:0]         ch_bypass,
    input  logic                   core_busy,
    input  logic                   core_done,
    input  logic                   clr_err,
    output logic                   core_start,
    output logic                   core_bypass,
    output logic [$clog2(NCH)-1:0] ch_sel,
    output logic [NCH-1:0]         grant,
    output logic                   sched_busy,
    output logic [NCH*CW-1:0]      frame_cnt,
    output logic [NCH-1:0]         err_sticky
);

    localparam int              IW       = $clog2(NCH);
    localparam logic [IW-1:0]   LAST_RST = IW'(NCH - 1);
    localparam logic [TO_W-1:0] WB_LAST  = TO_W'(WB_LIMIT - 1);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [TO_W-1:0] wd;
    logic [TO_W-1:0] wd_inc;
    logic [IW-1:0]   last_winner;
    logic [NCH-1:0]  arb_winner;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            do_grant;
    logic            frame_done;
    logic            wb_fail;
    logic            err_hit;
    logic [NCH-1:0]  err_set;

    assign wd_inc  = wd + 1'b1;
    assign err_hit = wb_fail || (state == ST_ABORT);
    assign err_set = err_hit ? grant : '0;

    intpol2_rr_arb #(
        .NCH (NCH)
    ) u_arb (
        .req        (ch_req & ch_en),
        .last       (last_winner),
        .winner     (arb_winner),
        .winner_idx (arb_idx),
        .any        (arb_any)
    );

    // Next-state decode and per-cycle event flags
    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        frame_done = 1'b0;
        wb_fail    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && arb_any) begin
                    do_grant  = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (core_busy) begin
                    state_nxt = ST_RUN;
                end else if (wd == WB_LAST) begin
                    wb_fail   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (core_done) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_IDLE;
                end else if (wd_inc == '1) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_ABORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, grant registers and registered core controls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            sched_busy  <= 1'b0;
            core_start  <= 1'b0;
            core_bypass <= 1'b0;
            ch_sel      <= '0;
            grant       <= '0;
            last_winner <= LAST_RST;
        end else begin
            state      <= state_nxt;
            sched_busy <= (state_nxt != ST_IDLE);
            // start pulse follows START (new frame) or ABORT (clear core)
            core_start <= (state == ST_START) || (state == ST_ABORT);
            if (do_grant) begin
                grant       <= arb_winner;
                ch_sel      <= arb_idx;
                core_bypass <= ch_bypass[arb_idx];
            end else if (frame_done || err_hit) begin
                grant       <= '0;
                last_winner <= ch_sel;
            end
        end
    end

    // Shared counter: busy-acknowledge timer in WAIT_BUSY, watchdog in RUN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd <= '0;
        end else begin
            case (state)
                ST_START:     wd <= '0;
                ST_WAIT_BUSY: wd <= core_busy ? '0 : wd_inc;
                ST_RUN:       wd <= wd_inc;
                default:      wd <= wd;
            endcase
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_sticky <= '0;
        end else begin
            err_sticky <= clr_err ? err_set : (err_sticky | err_set);
        end
    end

    // Saturating per-channel completed-frame counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (grant[i] && (frame_cnt[i*CW +: CW] != '1)) begin
                    frame_cnt[i*CW +: CW] <= frame_cnt[i*CW +: CW] + 1'b1;
                end
            end
        end
    end

endmodule
